// File: rtl/elevator_dut.sv
// Five-floor single-car elevator controller using a SCAN policy.
// Latches level-sensitive calls, moves one floor per clock, and stops one cycle at each served floor.
module elevator_dut (
  input  logic       clock,
  input  logic       reset,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  input  logic       f4,
  input  logic       f5,
  output logic [2:0] floor_number,
  output logic       dir,
  output logic       move,
  output logic [4:0] to_go
);

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic [2:0] floor_q, floor_d;
  dir_e       dir_q, dir_d;
  logic       move_q, move_d;
  logic [4:0] to_go_q, to_go_d;

  logic [4:0] req;
  logic [4:0] pend;
  logic [4:0] cur;
  logic [4:0] above;
  logic [4:0] below;
  logic [2:0] floor_idx;

  always_comb begin
    req       = {f5, f4, f3, f2, f1};
    pend      = to_go_q | req;
    floor_idx = floor_q - 3'd1;
    cur       = 5'd1 << floor_idx;
    above     = '0;
    below     = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (3'(i) > floor_idx) above[i] = pend[i];
      if (3'(i) < floor_idx) below[i] = pend[i];
    end
  end

  // Priority: serve current floor, continue/turn up, go down, idle.
  always_comb begin
    floor_d = floor_q;
    dir_d   = dir_q;
    move_d  = 1'b0;
    to_go_d = to_go_q;
    if ((pend & cur) != '0) begin
      to_go_d = pend & ~cur;
    end else if (above != '0 && (dir_q == DIR_UP || below == '0)) begin
      dir_d   = DIR_UP;
      floor_d = floor_q + 3'd1;
      move_d  = 1'b1;
      to_go_d = pend;
    end else if (below != '0) begin
      dir_d   = DIR_DOWN;
      floor_d = floor_q - 3'd1;
      move_d  = 1'b1;
      to_go_d = pend;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      floor_q <= 3'd1;
      dir_q   <= DIR_UP;
      move_q  <= 1'b0;
      to_go_q <= '0;
    end else begin
      floor_q <= floor_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      to_go_q <= to_go_d;
    end
  end

  assign floor_number = floor_q;
  assign dir          = dir_q;
  assign move         = move_q;
  assign to_go        = to_go_q;

endmodule

// File: tb/tb_elevator_dut.sv
// Scoreboard bench for elevator_dut: expected outputs are queued with each stimulus
// cycle and compared against the DUT one time unit after the following rising edge.
module tb_elevator_dut;

  logic       clock;
  logic       reset;
  logic       f1, f2, f3, f4, f5;
  logic [2:0] floor_number;
  logic       dir;
  logic       move;
  logic [4:0] to_go;

  int unsigned checks;
  int unsigned failures;

  typedef struct packed {
    logic [2:0] fl;
    logic       d;
    logic       m;
    logic [4:0] tg;
  } exp_t;

  exp_t exp_q[$];

  elevator_dut u_dut (
    .clock       (clock),
    .reset       (reset),
    .f1          (f1),
    .f2          (f2),
    .f3          (f3),
    .f4          (f4),
    .f5          (f5),
    .floor_number(floor_number),
    .dir         (dir),
    .move        (move),
    .to_go       (to_go)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [2:0] fl, input logic d, input logic m, input logic [4:0] tg);
    exp_t e;
    e.fl = fl;
    e.d  = d;
    e.m  = m;
    e.tg = tg;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_floor"}, {5'd0, floor_number}, {5'd0, e.fl});
      check_eq({tag, "_dir"},   {7'd0, dir},          {7'd0, e.d});
      check_eq({tag, "_move"},  {7'd0, move},         {7'd0, e.m});
      check_eq({tag, "_to_go"}, {3'd0, to_go},        {3'd0, e.tg});
    end
  endtask

  // Drive requests, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input string tag, input logic [4:0] req,
                      input logic [2:0] fl, input logic d, input logic m, input logic [4:0] tg);
    {f5, f4, f3, f2, f1} = req;
    sb_push(fl, d, m, tg);
    @(posedge clock);
    #1;
    sb_compare(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    {f5, f4, f3, f2, f1} = 5'b10000;

    // Reset held with f5 asserted across several edges.
    repeat (3) @(posedge clock);
    #1;
    sb_push(3'd1, 1'b1, 1'b0, 5'b00000);
    sb_compare("reset_hold");

    reset = 1'b1;
    step("up1",      5'b10000, 3'd2, 1'b1, 1'b1, 5'b10000);
    step("up2",      5'b10000, 3'd3, 1'b1, 1'b1, 5'b10000);
    step("up3",      5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    step("up4",      5'b10000, 3'd5, 1'b1, 1'b1, 5'b10000);
    step("stop5",    5'b10000, 3'd5, 1'b1, 1'b0, 5'b00000);
    step("held5",    5'b10000, 3'd5, 1'b1, 1'b0, 5'b00000);
    step("idle5",    5'b00000, 3'd5, 1'b1, 1'b0, 5'b00000);

    // Single-cycle pulse of f1 from the top floor.
    step("dn4",      5'b00001, 3'd4, 1'b0, 1'b1, 5'b00001);
    step("dn3",      5'b00000, 3'd3, 1'b0, 1'b1, 5'b00001);
    step("dn2",      5'b00000, 3'd2, 1'b0, 1'b1, 5'b00001);
    step("dn1",      5'b00000, 3'd1, 1'b0, 1'b1, 5'b00001);
    step("stop1",    5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000);

    // f2 and f4 together: intermediate stop at 2 on the way to 4.
    step("m_up2",    5'b01010, 3'd2, 1'b1, 1'b1, 5'b01010);
    step("m_stop2",  5'b00000, 3'd2, 1'b1, 1'b0, 5'b01000);
    step("m_up3",    5'b00000, 3'd3, 1'b1, 1'b1, 5'b01000);
    step("m_up4",    5'b00000, 3'd4, 1'b1, 1'b1, 5'b01000);
    step("m_stop4",  5'b00000, 3'd4, 1'b1, 1'b0, 5'b00000);

    // Reposition to floor 3 heading up.
    step("p_dn3",    5'b00010, 3'd3, 1'b0, 1'b1, 5'b00010);
    step("p_dn2",    5'b00000, 3'd2, 1'b0, 1'b1, 5'b00010);
    step("p_stop2",  5'b00000, 3'd2, 1'b0, 1'b0, 5'b00000);
    step("p_up3",    5'b00100, 3'd3, 1'b1, 1'b1, 5'b00100);
    step("p_stop3",  5'b00000, 3'd3, 1'b1, 1'b0, 5'b00000);

    // Requests above and below at once: current direction (up) wins.
    step("s_up4",    5'b10001, 3'd4, 1'b1, 1'b1, 5'b10001);
    step("s_up5",    5'b00000, 3'd5, 1'b1, 1'b1, 5'b10001);
    step("s_stop5",  5'b00000, 3'd5, 1'b1, 1'b0, 5'b00001);
    step("s_dn4",    5'b00000, 3'd4, 1'b0, 1'b1, 5'b00001);
    step("s_dn3",    5'b00000, 3'd3, 1'b0, 1'b1, 5'b00001);
    step("s_dn2",    5'b00000, 3'd2, 1'b0, 1'b1, 5'b00001);
    step("s_dn1",    5'b00000, 3'd1, 1'b0, 1'b1, 5'b00001);
    step("s_stop1",  5'b00000, 3'd1, 1'b0, 1'b0, 5'b00000);
    step("held1",    5'b00001, 3'd1, 1'b0, 1'b0, 5'b00000);

    // Go to floor 3 and sit idle.
    step("i_up2",    5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100);
    step("i_up3",    5'b00000, 3'd3, 1'b1, 1'b1, 5'b00100);
    step("i_stop3",  5'b00000, 3'd3, 1'b1, 1'b0, 5'b00000);
    for (int i = 0; i < 10; i++)
      step("idle3",  5'b00000, 3'd3, 1'b1, 1'b0, 5'b00000);

    // Asynchronous reset mid-travel, observed before any further clock edge.
    step("r_up4",    5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    {f5, f4, f3, f2, f1} = 5'b00000;
    #2;
    reset = 1'b0;
    #1;
    sb_push(3'd1, 1'b1, 1'b0, 5'b00000);
    sb_compare("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    step("post_rst", 5'b00000, 3'd1, 1'b1, 1'b0, 5'b00000);

    check_eq("sb_drained", {7'd0, exp_q.size() == 0}, 8'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_dut.md
Name: elevator_dut

Overview:
- Controller for a single elevator serving 5 floors (1..5).
- Level-sensitive call inputs f1..f5 are latched into a pending-request register.
- The car moves one floor per clock using a SCAN policy: keep direction while requests lie ahead, otherwise reverse.
- Sits between the call-button logic and the car drive/indicator logic.

Parameters:
- none. Floor count fixed at 5; travel time fixed at 1 clock per floor.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- f1  input  1  call request for floor 1, sampled every rising edge, level-sensitive.
- f2  input  1  call request for floor 2.
- f3  input  1  call request for floor 3.
- f4  input  1  call request for floor 4.
- f5  input  1  call request for floor 5.
- floor_number  output  3  current floor, binary 1..5; values 0, 6, 7 never driven.
- dir  output  1  travel direction: 1 = up, 0 = down.
- move  output  1  1 when floor_number changed at the most recent rising edge.
- to_go  output  5  pending requests; bit i = floor i+1 (bit0 = floor 1 … bit4 = floor 5).

Behaviour:
- Reset (reset=0, asynchronous, independent of clock):
  - floor_number=1, dir=1, move=0, to_go=5'b00000.
  - Reset has priority over everything, including mid-travel; all inputs are ignored while reset is low.
- All outputs are registered; no combinational input-to-output paths.
- Each rising edge with reset=1:
  - req = {f5,f4,f3,f2,f1}
  - pend = to_go | req
  - cur = one-hot bit of floor_number
  - above = pend bits for floors > floor_number; below = pend bits for floors < floor_number.
- Decision, first match wins:
  1. pend & cur != 0 (serve current floor): to_go <= pend & ~cur; floor unchanged; move<=0; dir unchanged.
  2. above != 0 and (dir==1 or below==0): dir<=1; floor_number<=floor_number+1; move<=1; to_go<=pend.
  3. below != 0: dir<=0; floor_number<=floor_number-1; move<=1; to_go<=pend.
  4. otherwise (idle): move<=0; dir, floor and to_go unchanged (to_go = 0).
- Consequences:
  - One floor per cycle; one stop cycle (move=0) at each served floor.
  - Intermediate floors with pending requests are served when reached, in either direction.
- Boundary conditions:
  - Cannot go above 5 or below 1, since above/below are empty at the extremes.
  - Request held high at the current floor: re-served every cycle, car stays, move=0, bit reads 0 in to_go.
  - Simultaneous requests above and below: the current dir wins. From reset (dir=1) the car goes up first.
  - A request arriving while the car passes that floor: it is latched on that edge, so the car serves it only if the car is at that floor at the next evaluation. Otherwise it stays pending until the sweep returns.
  - Request bits clear only by serving; input deassertion does not clear a latched bit.
- Latency: request to first movement is 1 edge. Total service time = |target - current| edges + 1 stop edge.

Test Plan:
- Reset: hold reset=0 with f5=1 and toggling clock -> floor_number=1, dir=1, move=0, to_go=0. Asserting reset=0 mid-travel forces the same values immediately, without a clock edge.
- Release reset with f5 held: edges 1-4 -> floor_number 2,3,4,5, move=1, dir=1, to_go=5'b10000. Edge 5 -> floor 5, move=0, to_go=0. Further edges -> stays at 5, move=0.
- At floor 5, pulse f1 for one cycle -> to_go=5'b00001, dir=0. Floors 4,3,2,1 on successive edges with move=1, then stop at 1 with move=0 and to_go=0.
- At floor 1, assert f2 and f4 together, then release -> to_go=5'b01010. Edge 1: floor 2, move=1. Edge 2: stop at 2, to_go=5'b01000. Edges 3-4: floors 3,4. Edge 5: stop at 4, to_go=0.
- At floor 3 with dir=1, assert f1 and f5 in the same cycle -> car continues up to 5 and stops, then reverses (dir=0) down to 1 and stops; to_go ends at 0.
- Idle at floor 3 with no requests for 10 cycles -> floor_number=3, move=0, dir and to_go unchanged.
